// File: rtl/parallel_block_receiver_if.sv
// Dispatcher/core-facing bundle of the per-core block receiver.
// slave: the receiver; master: whatever drives it (dispatcher + core).
interface parallel_block_receiver_if #(
  parameter int WBW         = 16,
  parameter int VDIM        = 4,
  parameter int MAX_PENDING = 4
);
  localparam int CW = $clog2(MAX_PENDING + 1);

  logic                      bofs_rdy;
  logic                      bofs_ack;
  logic [VDIM-1:0][WBW-1:0]  i_bofs;
  logic                      blk_rdy;
  logic                      blk_ack;
  logic [VDIM-1:0][WBW-1:0]  o_bofs;
  logic                      i_blk_fin;
  logic                      blkdone_dval;
  logic [CW-1:0]             o_n_inflight;
  logic                      o_idle;
  logic                      o_err;

  modport slave (
    input  bofs_rdy,
    input  i_bofs,
    input  blk_ack,
    input  i_blk_fin,
    output bofs_ack,
    output blk_rdy,
    output o_bofs,
    output blkdone_dval,
    output o_n_inflight,
    output o_idle,
    output o_err
  );

  modport master (
    output bofs_rdy,
    output i_bofs,
    output blk_ack,
    output i_blk_fin,
    input  bofs_ack,
    input  blk_rdy,
    input  o_bofs,
    input  blkdone_dval,
    input  o_n_inflight,
    input  o_idle,
    input  o_err
  );
endinterface

// File: rtl/parallel_block_receiver.sv
// Per-core block-offset receiver: offset FIFO, in-order issue to the
// core, in-flight credit counter and registered block-done pulse.
module parallel_block_receiver #(
  parameter int WBW         = 16,
  parameter int VDIM        = 4,
  parameter int MAX_PENDING = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  parallel_block_receiver_if.slave bus
);
  localparam int CW = $clog2(MAX_PENDING + 1);
  localparam int PW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam logic [CW-1:0] MP_CNT = CW'(MAX_PENDING);
  localparam logic [PW-1:0] LAST   = PW'(MAX_PENDING - 1);

  typedef logic [VDIM-1:0][WBW-1:0] ofs_t;

  ofs_t          mem [MAX_PENDING];
  logic [CW-1:0] fifo_cnt;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] n_inflight;
  logic          done_q;
  logic          err_q;

  logic push;
  logic pop;
  logic rdy_out;
  logic fin_ok;
  logic fin_err;
  logic ack_err;

  // Full FIFO refuses a push even if the head leaves this cycle.
  assign push    = bus.bofs_rdy && (fifo_cnt != MP_CNT);
  assign rdy_out = (fifo_cnt != '0) && (n_inflight != MP_CNT);
  assign pop     = bus.blk_ack && rdy_out;
  assign fin_ok  = bus.i_blk_fin && ((n_inflight != '0) || pop);
  assign fin_err = bus.i_blk_fin && !fin_ok;
  assign ack_err = bus.blk_ack && !rdy_out;

  assign bus.bofs_ack     = push;
  assign bus.blk_rdy      = rdy_out;
  assign bus.o_bofs       = mem[rd_ptr];
  assign bus.blkdone_dval = done_q;
  assign bus.o_n_inflight = n_inflight;
  assign bus.o_err        = err_q;
  assign bus.o_idle       = (fifo_cnt == '0) && (n_inflight == '0);

  // Offset storage, written at the write pointer on each accepted push.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < MAX_PENDING; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= bus.i_bofs;
    end
  end

  // FIFO pointers wrap explicitly so non-power-of-2 depths work.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
      unique case (1'b1)
        push && !pop: fifo_cnt <= fifo_cnt + 1'b1;
        pop && !push: fifo_cnt <= fifo_cnt - 1'b1;
        default:      fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // In-flight credit count: issue adds one, accepted finish removes one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      n_inflight <= '0;
    end else begin
      unique case (1'b1)
        pop && !fin_ok: n_inflight <= n_inflight + 1'b1;
        fin_ok && !pop: n_inflight <= n_inflight - 1'b1;
        default:        n_inflight <= n_inflight;
      endcase
    end
  end

  // Done pulse follows each accepted finish; protocol errors are sticky.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= fin_ok;
      err_q  <= err_q || fin_err || ack_err;
    end
  end
endmodule

// File: tb/tb_parallel_block_receiver.sv
// Directed bench for parallel_block_receiver.
// Inputs change on the falling edge; outputs checked 1ns later.
module tb_parallel_block_receiver;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  parallel_block_receiver_if #(.WBW(16), .VDIM(4), .MAX_PENDING(4)) bus ();

  parallel_block_receiver #(
    .WBW(16), .VDIM(4), .MAX_PENDING(4)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] mk(input int n);
    return {16'(n), 16'(n + 1), 16'(n + 2), 16'(n + 3)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [63:0] d,
                      input logic a, input logic f);
    @(negedge clk);
    bus.bofs_rdy  = r;
    bus.i_bofs    = d;
    bus.blk_ack   = a;
    bus.i_blk_fin = f;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.bofs_rdy  = 1'b0;
    bus.i_bofs    = '0;
    bus.blk_ack   = 1'b0;
    bus.i_blk_fin = 1'b0;
    #1;
    chk("rst_blk_rdy", bus.blk_rdy, 0);
    chk("rst_obofs", bus.o_bofs, 0);
    chk("rst_done", bus.blkdone_dval, 0);
    chk("rst_err", bus.o_err, 0);
    chk("rst_infl", bus.o_n_inflight, 0);
    chk("rst_idle", bus.o_idle, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single block
    step(1, mk(1), 0, 0);
    chk("t1_ack", bus.bofs_ack, 1);
    chk("t1_nobypass", bus.blk_rdy, 0);
    step(0, 0, 0, 0);
    chk("t1_rdy", bus.blk_rdy, 1);
    chk("t1_obofs", bus.o_bofs, mk(1));
    chk("t1_noack", bus.bofs_ack, 0);
    step(0, 0, 1, 0);
    chk("t1_infl0", bus.o_n_inflight, 0);
    step(0, 0, 0, 0);
    chk("t1_infl1", bus.o_n_inflight, 1);
    chk("t1_rdy0", bus.blk_rdy, 0);
    chk("t1_busy", bus.o_idle, 0);
    step(0, 0, 0, 1);
    chk("t1_done_early", bus.blkdone_dval, 0);
    step(0, 0, 0, 0);
    chk("t1_done", bus.blkdone_dval, 1);
    chk("t1_infl_end", bus.o_n_inflight, 0);
    chk("t1_idle", bus.o_idle, 1);
    step(0, 0, 0, 0);
    chk("t1_done_off", bus.blkdone_dval, 0);

    // 2: fill, full back-pressure, then 4: credit stall
    for (int i = 0; i < 4; i++) begin
      step(1, mk(10 + i), 0, 0);
      chk("t2_fill_ack", bus.bofs_ack, 1);
    end
    step(1, mk(14), 0, 0);
    chk("t2_full_nack", bus.bofs_ack, 0);
    chk("t2_rdy", bus.blk_rdy, 1);
    chk("t2_head", bus.o_bofs, mk(10));
    step(1, mk(14), 1, 0);
    chk("t2_full_pop_nack", bus.bofs_ack, 0);
    step(1, mk(14), 0, 0);
    chk("t2_after_pop_ack", bus.bofs_ack, 1);
    chk("t2_head11", bus.o_bofs, mk(11));
    chk("t2_infl1", bus.o_n_inflight, 1);
    for (int i = 1; i < 4; i++) begin
      step(0, 0, 1, 0);
      chk("t2_pop_rdy", bus.blk_rdy, 1);
      chk("t2_pop_order", bus.o_bofs, mk(10 + i));
    end
    step(0, 0, 0, 0);
    chk("t4_infl4", bus.o_n_inflight, 4);
    chk("t4_stall", bus.blk_rdy, 0);
    chk("t4_head14", bus.o_bofs, mk(14));
    step(0, 0, 0, 1);
    chk("t4_stall_fin", bus.blk_rdy, 0);
    step(0, 0, 1, 0);
    chk("t4_release", bus.blk_rdy, 1);
    chk("t4_done", bus.blkdone_dval, 1);
    chk("t4_infl3", bus.o_n_inflight, 3);
    chk("t4_pop14", bus.o_bofs, mk(14));
    step(0, 0, 0, 1);
    chk("t4_done_c", bus.blkdone_dval, 0);
    chk("t4_infl_c", bus.o_n_inflight, 4);
    step(0, 0, 0, 1);
    chk("t4_done_d", bus.blkdone_dval, 1);
    chk("t4_infl_d", bus.o_n_inflight, 3);
    step(0, 0, 0, 1);
    chk("t4_done_e", bus.blkdone_dval, 1);
    chk("t4_infl_e", bus.o_n_inflight, 2);
    step(0, 0, 0, 1);
    chk("t4_done_f", bus.blkdone_dval, 1);
    chk("t4_infl_f", bus.o_n_inflight, 1);
    step(0, 0, 0, 0);
    chk("t4_done_g", bus.blkdone_dval, 1);
    chk("t4_infl_g", bus.o_n_inflight, 0);
    chk("t4_idle", bus.o_idle, 1);
    chk("t4_err", bus.o_err, 0);

    // 3: 9 streamed blocks, pointers wrap twice
    for (int c = 0; c < 14; c++) begin
      step(c < 9, mk(30 + c), (c >= 1) && (c <= 9),
           (c >= 3) && (c <= 11));
      chk("t3_ack", bus.bofs_ack, (c < 9));
      if ((c >= 1) && (c <= 9)) begin
        chk("t3_rdy", bus.blk_rdy, 1);
        chk("t3_order", bus.o_bofs, mk(29 + c));
      end
      chk("t3_done", bus.blkdone_dval, (c >= 4) && (c <= 12));
    end
    chk("t3_idle", bus.o_idle, 1);
    chk("t3_infl", bus.o_n_inflight, 0);
    chk("t3_err", bus.o_err, 0);

    // 5: simultaneous push+pop and ack+fin
    step(1, mk(20), 0, 0);
    chk("t5_ack0", bus.bofs_ack, 1);
    step(1, mk(21), 0, 0);
    chk("t5_ack1", bus.bofs_ack, 1);
    chk("t5_head20", bus.o_bofs, mk(20));
    step(1, mk(22), 1, 0);
    chk("t5_pushpop_ack", bus.bofs_ack, 1);
    step(0, 0, 1, 1);
    chk("t5_head21", bus.o_bofs, mk(21));
    chk("t5_infl1", bus.o_n_inflight, 1);
    step(0, 0, 1, 0);
    chk("t5_infl_keep", bus.o_n_inflight, 1);
    chk("t5_pulse", bus.blkdone_dval, 1);
    chk("t5_head22", bus.o_bofs, mk(22));
    step(0, 0, 0, 0);
    chk("t5_cnt_empty", bus.blk_rdy, 0);
    chk("t5_infl2", bus.o_n_inflight, 2);
    chk("t5_nopulse", bus.blkdone_dval, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("t5_pulse2", bus.blkdone_dval, 1);
    step(0, 0, 0, 0);
    chk("t5_idle", bus.o_idle, 1);
    chk("t5_err", bus.o_err, 0);

    // 6: protocol errors
    step(0, 0, 0, 1);
    chk("t6_err_pre", bus.o_err, 0);
    step(0, 0, 0, 0);
    chk("t6_fin_err", bus.o_err, 1);
    chk("t6_fin_nopulse", bus.blkdone_dval, 0);
    chk("t6_fin_infl", bus.o_n_inflight, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_err_clr", bus.o_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 1, 0);
    chk("t6_stray_rdy", bus.blk_rdy, 0);
    step(0, 0, 0, 0);
    chk("t6_ack_err", bus.o_err, 1);
    chk("t6_ack_infl", bus.o_n_inflight, 0);
    chk("t6_ack_idle", bus.o_idle, 1);

    // 6: asynchronous reset with 3 buffered and a pulse pending
    for (int i = 0; i < 3; i++) begin
      step(1, mk(40 + i), 0, 0);
      chk("t6_fill", bus.bofs_ack, 1);
    end
    step(0, 0, 1, 0);
    chk("t6_head40", bus.o_bofs, mk(40));
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("t6_pend_pulse", bus.blkdone_dval, 1);
    chk("t6_head41", bus.o_bofs, mk(41));
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_ar_done", bus.blkdone_dval, 0);
    chk("t6_ar_err", bus.o_err, 0);
    chk("t6_ar_rdy", bus.blk_rdy, 0);
    chk("t6_ar_obofs", bus.o_bofs, 0);
    chk("t6_ar_infl", bus.o_n_inflight, 0);
    chk("t6_ar_idle", bus.o_idle, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    chk("t6_post_rdy", bus.blk_rdy, 0);
    chk("t6_post_idle", bus.o_idle, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
